deficit_rr_scheduler: RTL and testbench

DEFICIT_RR_SCHEDULER -- requirements
Module: deficit_rr_scheduler

---
 rtl/deficit_rr_scheduler_pkg.sv | 23 ++
 rtl/deficit_rr_scheduler_deficit_cnt.sv | 44 ++++
 rtl/deficit_rr_scheduler.sv | 111 +++++++++++
 tb/tb_deficit_rr_scheduler.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/deficit_rr_scheduler_pkg.sv
// Shared types for the deficit round-robin scheduler: FSM states, counter
// operations and the deficit width derivation.
package sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SERVE
    } state_t;

    typedef enum logic [1:0] {
        CNT_HOLD,
        CNT_ADD,
        CNT_SUB,
        CNT_CLR
    } cnt_op_t;

    // One extra bit of headroom so a leftover deficit plus a full quantum fits.
    function automatic int dwid(input int qwid);
        return qwid + 1;
    endfunction

endpackage

// File: rtl/deficit_rr_scheduler_deficit_cnt.sv
// Per-requester deficit counter: saturating quantum add, packet-cost subtract,
// clear and hold, selected by the scheduler each cycle.
module deficit_cnt
    import sched_pkg::*;
#(
    parameter int QWID  = 8,
    parameter int PSIZE = 8,
    localparam int DWID = dwid(QWID)
) (
    input  logic            clk,
    input  logic            rst,
    input  cnt_op_t         op,
    input  logic [QWID-1:0] quantum,
    output logic [DWID-1:0] deficit
);

    localparam logic [DWID-1:0] PCOST = DWID'(PSIZE);

    function automatic logic [DWID-1:0] sat_add(input logic [DWID-1:0] a,
                                                input logic [QWID-1:0] b);
        logic [DWID:0] sum;
        sum = {1'b0, a} + {2'b00, b};
        return sum[DWID] ? {DWID{1'b1}} : sum[DWID-1:0];
    endfunction

    // The scheduler only subtracts when the cost is covered; the floor is a guard.
    function automatic logic [DWID-1:0] sub_floor(input logic [DWID-1:0] a);
        return (a >= PCOST) ? (a - PCOST) : '0;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deficit <= '0;
        end else begin
            case (op)
                CNT_ADD:  deficit <= sat_add(deficit, quantum);
                CNT_SUB:  deficit <= sub_floor(deficit);
                CNT_CLR:  deficit <= '0;
                default:  deficit <= deficit;
            endcase
        end
    end

endmodule

// File: rtl/deficit_rr_scheduler.sv
// Deficit round-robin scheduler over NUM_REQS FIFO heads with a fixed packet cost.
// Optional build macro STRICT_PRIO_EN gives requester 0 absolute priority.
module deficit_rr_scheduler
    import sched_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int QWID     = 8,
    parameter int PSIZE    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         blk,
    input  logic [NUM_REQS-1:0]          reqs,
    input  logic [NUM_REQS*QWID-1:0]     input_quantums,
    output logic [NUM_REQS-1:0]          gnt,
    output logic                         gnt_vld,
    output logic [$clog2(NUM_REQS)-1:0]  ptr
);

    localparam int DWID = dwid(QWID);
    localparam int PW   = $clog2(NUM_REQS);
    localparam logic [PW-1:0]   LAST  = PW'(NUM_REQS - 1);
    localparam logic [DWID-1:0] PCOST = DWID'(PSIZE);

    state_t          state;
    logic [DWID-1:0] deficit [NUM_REQS];
    cnt_op_t         op      [NUM_REQS];
    logic            serving;
    logic            can_send;
    logic            send;
    logic            prio;

    assign serving  = (state == SERVE) && !blk;
    assign can_send = reqs[ptr] && (deficit[ptr] >= PCOST);
    // Gating with rst drops a grant in the very cycle reset is asserted.
    assign send     = rst && serving && can_send;

`ifdef STRICT_PRIO_EN
    assign prio = rst && reqs[0] && !blk;
`else
    assign prio = 1'b0;
`endif

    always_comb begin
        gnt = '0;
        if (prio) begin
            gnt[0] = 1'b1;
        end else if (send) begin
            gnt[ptr] = 1'b1;
        end
    end

    assign gnt_vld = |gnt;

    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            op[i] = CNT_HOLD;
            if (!prio && (PW'(i) == ptr)) begin
                if (state == LOAD) begin
                    op[i] = CNT_ADD;
                end else if (serving) begin
                    if (can_send) begin
                        op[i] = CNT_SUB;
                    end else if (!reqs[ptr]) begin
                        op[i] = CNT_CLR;
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_REQS; i++) begin : g_cnt
        deficit_cnt #(
            .QWID  (QWID),
            .PSIZE (PSIZE)
        ) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .op      (op[i]),
            .quantum (input_quantums[i*QWID +: QWID]),
            .deficit (deficit[i])
        );
    end

    // A priority grant freezes the round-robin state entirely.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ptr   <= '0;
        end else if (!prio) begin
            case (state)
                IDLE: begin
                    if (|reqs) state <= LOAD;
                end
                LOAD: begin
                    state <= SERVE;
                end
                SERVE: begin
                    if (!blk && !can_send) begin
                        ptr   <= (ptr == LAST) ? '0 : ptr + 1'b1;
                        state <= (|reqs) ? LOAD : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_deficit_rr_scheduler.sv
// Directed bench for deficit_rr_scheduler with a cycle-level DRR reference model.
module tb_deficit_rr_scheduler;

    localparam int N    = 4;
    localparam int QW   = 8;
    localparam int PS   = 8;
    localparam int DMAX = 511;
`ifdef STRICT_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          blk = 1'b0;
    logic [N-1:0]  reqs = '0;
    logic [N*QW-1:0] quants = '0;
    logic [N-1:0]  gnt;
    logic          gnt_vld;
    logic [1:0]    ptr;

    deficit_rr_scheduler #(.NUM_REQS(N), .QWID(QW), .PSIZE(PS)) dut (
        .clk            (clk),
        .rst            (rst),
        .blk            (blk),
        .reqs           (reqs),
        .input_quantums (quants),
        .gnt            (gnt),
        .gnt_vld        (gnt_vld),
        .ptr            (ptr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t0 = 0;

    typedef struct { int c; int idx; } gev_t;
    gev_t glog[$];
    int exp_c[$];
    int exp_i[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 = idle, 1 = topping up the current requester,
    // 2 = spending its deficit. Evaluated once per cycle on the falling edge.
    int m_def[N];
    int m_ptr  = 0;
    int m_mode = 0;
    int e_gnt;
    int e_ptr;
    int gi;

    always @(negedge clk) begin
        e_gnt = 0;
        e_ptr = m_ptr;
        if (!rst) begin
            m_mode = 0;
            m_ptr  = 0;
            e_ptr  = 0;
            for (int i = 0; i < N; i++) m_def[i] = 0;
        end else if (PRIO && reqs[0] && !blk) begin
            e_gnt = 1;
        end else if (m_mode == 0) begin
            if (reqs != 0) m_mode = 1;
        end else if (m_mode == 1) begin
            m_def[m_ptr] = m_def[m_ptr] + int'(quants[m_ptr*QW +: QW]);
            if (m_def[m_ptr] > DMAX) m_def[m_ptr] = DMAX;
            m_mode = 2;
        end else if (!blk) begin
            if (reqs[m_ptr] && m_def[m_ptr] >= PS) begin
                e_gnt = 1 << m_ptr;
                m_def[m_ptr] = m_def[m_ptr] - PS;
            end else begin
                if (!reqs[m_ptr]) m_def[m_ptr] = 0;
                m_ptr  = (m_ptr + 1) % N;
                m_mode = (reqs != 0) ? 1 : 0;
            end
        end
        check("gnt", int'(gnt), e_gnt);
        check("gnt_vld", int'(gnt_vld), int'(e_gnt != 0));
        check("ptr", int'(ptr), e_ptr);
        if (gnt_vld) begin
            gi = 0;
            for (int i = 0; i < N; i++) if (gnt[i]) gi = i;
            glog.push_back('{c: cyc - t0, idx: gi});
        end
    end

    task automatic run_test(input logic [N*QW-1:0] q, input logic [N-1:0] r, input int n,
                            input int blk_lo, input int blk_hi, input int drop_at,
                            input int rst_at, input logic [N-1:0] pre_rst_gnt);
        rst = 1'b0; blk = 1'b0; reqs = '0; quants = q;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                t0 = cyc;
                glog.delete();
            end
            reqs = (c >= drop_at) ? '0 : r;
            blk  = (c >= blk_lo) && (c < blk_hi);
            if (c == rst_at + 2) rst = 1'b1;
            if (c == rst_at) begin
                #1 check("pre_reset_gnt", int'(gnt), int'(pre_rst_gnt));
                rst = 1'b0;
                #1;
                check("reset_gnt", int'(gnt), 0);
                check("reset_gnt_vld", int'(gnt_vld), 0);
                check("reset_ptr", int'(ptr), 0);
            end
        end
        @(posedge clk);
        #1 reqs = '0; blk = 1'b0;
    endtask

    task automatic check_log(input string name);
        check({name, "_count"}, glog.size(), exp_c.size());
        for (int i = 0; i < glog.size() && i < exp_c.size(); i++) begin
            check({name, "_cycle"}, glog[i].c, exp_c[i]);
            check({name, "_idx"}, glog[i].idx, exp_i[i]);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", int'(gnt), 0);
        check("rst_gnt_vld", int'(gnt_vld), 0);
        check("rst_ptr", int'(ptr), 0);

`ifdef STRICT_PRIO_EN
        run_test(32'h10101010, 4'b1011, 10, 0, 0, 1000, 1000, 4'b0000);
        exp_c.delete(); exp_i.delete();
        for (int i = 0; i < 10; i++) begin
            exp_c.push_back(i);
            exp_i.push_back(0);
        end
        check_log("strict_prio");
        check("strict_prio_ptr", int'(ptr), 0);
`else
        // Single requester, quantum 16: two grants per visit, full lap between.
        run_test(32'h10101010, 4'b0001, 16, 0, 0, 14, 1000, 4'b0000);
        exp_c = '{2, 3, 12, 13};
        exp_i = '{0, 0, 0, 0};
        check_log("single");
        check("single_ptr_end", int'(ptr), 1);

        // Weighted quantums {8,16,8,24}: 1,2,1,3 grants per round.
        run_test(32'h18081008, 4'b1111, 30, 0, 0, 1000, 1000, 4'b0000);
        exp_c = '{2, 5, 6, 9, 12, 13, 14, 17, 20, 21, 24, 27, 28, 29};
        exp_i = '{0, 1, 1, 2, 3, 3, 3, 0, 1, 1, 2, 3, 3, 3};
        check_log("weighted");

        // Quantum 4 on requester 2: a grant on every second visit.
        run_test(32'h10041010, 4'b0100, 34, 0, 0, 1000, 1000, 4'b0000);
        exp_c = '{14, 31};
        exp_i = '{2, 2};
        check_log("fractional");

        // Block for five cycles of SERVE; deficit of 16 still yields two grants.
        run_test(32'h10101010, 4'b0001, 10, 2, 7, 1000, 1000, 4'b0000);
        exp_c = '{7, 8};
        exp_i = '{0, 0};
        check_log("block");

        // Reset asserted while requester 1 is being granted.
        run_test(32'h18081008, 4'b1111, 12, 0, 0, 1000, 6, 4'b0010);
        exp_c = '{2, 5, 10};
        exp_i = '{0, 1, 0};
        check_log("mid_reset");

        // Zero quantum on requester 0: never granted, FSM moves on.
        run_test(32'h10101000, 4'b0011, 12, 0, 0, 1000, 1000, 4'b0000);
        exp_c = '{4, 5};
        exp_i = '{1, 1};
        check_log("zero_quantum");
`endif

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
